// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and helpers for the serial add/subtract controller.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand request and result channels of the serial add/subtract controller.
// Both channels: a transfer happens on a rising edge where valid && ready; the
// source holds valid and its payload stable until that edge.
interface serial_add_ctrl_if #(parameter int WIDTH = serial_add_pkg::DEF_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             sub_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, sub_in, out_ready,
    input  in_ready, out_valid, sum_out, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, sub_in, out_ready,
    output in_ready, out_valid, sum_out, cout, ovf, busy
  );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder with its carry held in a flop; the carry can be preset.
module serial_fa_cell
  import serial_add_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic cin_init,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic carry
);
  logic carry_q;

  assign s     = a ^ b ^ carry_q;
  assign carry = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    carry_q <= 1'b0;
    else if (load) carry_q <= cin_init;
    else if (en)   carry_q <= fa_carry(a, b, carry_q);
  end
endmodule

// File: rtl/serial_add_ctrl.sv
// Sequences the serial full-adder cell LSB-first over WIDTH clocks and
// returns sum, carry-out and signed overflow through a valid/ready channel.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic   clk,
  input  logic   rst_n,
  serial_add_ctrl_if.slave bus,
  output state_t state_o
);
  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_out_q;
  logic [CW-1:0]    cnt_q;
  logic             cin_msb_q, out_valid_q, cout_q, ovf_q;
  logic             accept, shift_en, s_bit, carry, carry_nxt;

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign shift_en  = (state_q == SHIFT);
  assign carry_nxt = fa_carry(a_q[0], b_q[0], carry);

  serial_fa_cell u_cell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .cin_init (bus.sub_in),
    .en       (shift_en),
    .a        (a_q[0]),
    .b        (b_q[0]),
    .s        (s_bit),
    .carry    (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      sum_out_q   <= '0;
      cnt_q       <= '0;
      cin_msb_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a_in;
            b_q     <= bus.sub_in ? ~bus.b_in : bus.b_in;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sum_q <= {s_bit, sum_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          // Carry out of bit WIDTH-2 is the carry into the MSB.
          if (cnt_q == CW'(WIDTH-2)) cin_msb_q <= carry_nxt;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            sum_out_q   <= {s_bit, sum_q[WIDTH-1:1]};
            cout_q      <= carry_nxt;
            ovf_q       <= cin_msb_q ^ carry_nxt;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_out_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state_q != IDLE);
  assign state_o       = state_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) with an expected-result queue.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     cyc;
  int     vectors;
  int     miscompares;
  logic   ov_prev;

  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {sum, cout, ovf} from plain integer arithmetic and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W-1:0] s;
    logic c, v;
    if (!sub) begin
      s = a + b;
      c = (int'(a) + int'(b)) > 255;
      v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      s = a - b;
      c = (a >= b);
      v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end
    return {s, c, v};
  endfunction

  // driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      output int acc_edge);
    int n;
    n = 0;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.sub_in   = sub;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", n, 0);
    acc_edge = cyc + 1;
    exp_q.push_back(model(a, b, sub));
    acc_q.push_back(acc_edge);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a_in     = W'($urandom_range(0, 255));
    bus.b_in     = W'($urandom_range(0, 255));
    bus.sub_in   = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [W+1:0] e;
    int a;
    if (rst_n) begin
      if (bus.out_valid && !ov_prev) begin
        chk("valid_has_accept", (acc_q.size() > 0), 1);
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          chk("latency", cyc - a, W);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("result_pending", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sum_out", bus.sum_out, e[W+1:2]);
          chk("cout", bus.cout, e[1]);
          chk("ovf", bus.ovf, e[0]);
        end
      end
      ov_prev = bus.out_valid;
    end else begin
      ov_prev = 1'b0;
    end
  end

  initial begin : main
    int e0, e1, e2;
    logic [W+1:0] e;
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    ov_prev      = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    bus.sub_in   = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sum", bus.sum_out, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_state", state_dbg, IDLE);
    @(posedge clk);
    #1;

    // directed add/subtract vectors
    send(8'h35, 8'h4A, 1'b0, e0); drain();
    send(8'hFF, 8'h01, 1'b0, e0); drain();
    send(8'h7F, 8'h01, 1'b0, e0); drain();
    send(8'h10, 8'h01, 1'b1, e0); drain();
    send(8'h01, 8'h02, 1'b1, e0); drain();
    send(8'h80, 8'h01, 1'b1, e0); drain();

    // backpressure with a stray in_valid pulse during SHIFT
    bus.out_ready = 1'b0;
    send(8'h5A, 8'h33, 1'b0, e0);
    repeat (2) @(posedge clk);
    #1;
    bus.a_in = 8'hEE; bus.b_in = 8'h11; bus.sub_in = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("shift_in_ready", bus.in_ready, 0);
    chk("shift_busy", bus.busy, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("bp_valid_seen", bus.out_valid, 1);
    end
    e = model(8'h5A, 8'h33, 1'b0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_sum_hold", bus.sum_out, e[W+1:2]);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // reset four cycles into SHIFT
    send(8'h55, 8'h22, 1'b0, e0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h03, 8'h04, 1'b0, e0); drain();

    // back-to-back with in_valid and out_ready held high
    send(8'h12, 8'h34, 1'b0, e0);
    send(8'hC0, 8'h50, 1'b0, e1);
    send(8'h20, 8'h70, 1'b1, e2);
    chk("b2b_gap1", e1 - e0, W + 2);
    chk("b2b_gap2", e2 - e1, W + 2);
    drain();

    // random vectors with random consumer stalls
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), e0);
      repeat (W + $urandom_range(0, 3)) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end
endmodule
